parity_frame_tx: RTL and testbench

//   Serial parity-frame transmitter: the sending end of the serial parity link.
//   - Accepts a parallel word over a valid/ready handshake.
//   - Shifts the word out LSB-first, one bit per clk.
//   - Appends one parity bit so the downstream serial parity checker sees the configured parity.
//   - Sits between the word-level producer and the 1-bit serial line.

---
 rtl/parity_frame_tx_if.sv | 30 +++
 rtl/parity_frame_tx.sv | 79 +++++++
 tb/tb_parity_frame_tx.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/parity_frame_tx_if.sv
// Word-level handshake plus serial line bundle for the parity frame transmitter.
// The producer side uses the master modport and the transmitter uses the slave modport.
interface parity_frame_tx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] data_in;
    logic              valid_in;
    logic              ready_out;
    logic              tx_bit;
    logic              tx_valid;
    logic              tx_last;

    modport master (
        output data_in,
        output valid_in,
        input  ready_out,
        input  tx_bit,
        input  tx_valid,
        input  tx_last
    );

    modport slave (
        input  data_in,
        input  valid_in,
        output ready_out,
        output tx_bit,
        output tx_valid,
        output tx_last
    );
endinterface

// File: rtl/parity_frame_tx.sv
// Serial parity-frame transmitter: takes a word over valid/ready and sends it LSB-first,
// followed by one parity bit flagged with tx_last.
module parity_frame_tx #(
    parameter int DATA_W     = 8,
    parameter int ODD_PARITY = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    parity_frame_tx_if.slave    bus
);
    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] shreg;
    logic [CNT_W-1:0]  cnt;
    logic              par;
    logic              accept;
    logic              par_next;

    assign bus.ready_out = (state == IDLE) || (state == PARITY);

    always_comb begin
        accept   = bus.valid_in && bus.ready_out;
        par_next = (^bus.data_in) ^ (ODD_PARITY != 0);
    end

    // Bit 0 goes straight onto the line at accept, so shreg[0] always holds the next bit to send.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            shreg        <= '0;
            cnt          <= '0;
            par          <= 1'b0;
            bus.tx_bit   <= 1'b0;
            bus.tx_valid <= 1'b0;
            bus.tx_last  <= 1'b0;
        end else if (accept) begin
            state        <= DATA;
            shreg        <= bus.data_in >> 1;
            cnt          <= '0;
            par          <= par_next;
            bus.tx_bit   <= bus.data_in[0];
            bus.tx_valid <= 1'b1;
            bus.tx_last  <= 1'b0;
        end else begin
            case (state)
                DATA: begin
                    if (cnt == CNT_W'(DATA_W - 1)) begin
                        state       <= PARITY;
                        bus.tx_bit  <= par;
                        bus.tx_last <= 1'b1;
                    end else begin
                        shreg      <= shreg >> 1;
                        cnt        <= cnt + CNT_W'(1);
                        bus.tx_bit <= shreg[0];
                    end
                end
                PARITY: begin
                    state        <= IDLE;
                    bus.tx_bit   <= 1'b0;
                    bus.tx_valid <= 1'b0;
                    bus.tx_last  <= 1'b0;
                end
                default: begin
                    state        <= IDLE;
                    bus.tx_bit   <= 1'b0;
                    bus.tx_valid <= 1'b0;
                    bus.tx_last  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_parity_frame_tx.sv
// Scoreboard bench for parity_frame_tx: an even and an odd parity instance share one stimulus
// stream, and a negedge monitor compares every serial bit against frames built from the words.
module tb_parity_frame_tx;
    localparam int DATA_W = 8;

    typedef struct packed {
        logic last;
        logic b;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    parity_frame_tx_if #(.DATA_W(DATA_W)) bus_even ();
    parity_frame_tx_if #(.DATA_W(DATA_W)) bus_odd ();

    assign bus_odd.data_in  = bus_even.data_in;
    assign bus_odd.valid_in = bus_even.valid_in;

    parity_frame_tx #(.DATA_W(DATA_W), .ODD_PARITY(0)) dut_even (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_even)
    );

    parity_frame_tx #(.DATA_W(DATA_W), .ODD_PARITY(1)) dut_odd (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_odd)
    );

    exp_t q_even[$];
    exp_t q_odd[$];
    int   compared   = 0;
    int   mismatched = 0;
    logic chk_even   = 1'b0;
    logic chk_odd    = 1'b0;
    int   run_len    = 0;
    int   last_run   = 0;

    task automatic compare(input string name, input int act, input int req);
        compared++;
        if (act != req) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, required %0d at %0t", name, act, req, $time);
        end
    endtask

    // Reference frame: the data bits LSB-first, then a bit that makes the total weight even/odd.
    task automatic pushFrame(input logic [DATA_W-1:0] w);
        int ones;
        ones = $countones(w);
        for (int i = 0; i < DATA_W; i++) begin
            q_even.push_back('{1'b0, w[i]});
            q_odd.push_back('{1'b0, w[i]});
        end
        q_even.push_back('{1'b1, logic'(ones % 2)});
        q_odd.push_back('{1'b1, logic'((ones + 1) % 2)});
    endtask

    task automatic checkOutput(input int which, input logic b, input logic v, input logic l);
        exp_t e;
        logic chk;
        if (!v) begin
            compare(which == 0 ? "idle_even" : "idle_odd", int'({b, l}), 0);
        end else if ((which == 0 && q_even.size() == 0) || (which == 1 && q_odd.size() == 0)) begin
            compare(which == 0 ? "unexpected_valid_even" : "unexpected_valid_odd", int'(v), 0);
        end else begin
            e = (which == 0) ? q_even.pop_front() : q_odd.pop_front();
            compare(which == 0 ? "tx_bit_even" : "tx_bit_odd", int'(b), int'(e.b));
            compare(which == 0 ? "tx_last_even" : "tx_last_odd", int'(l), int'(e.last));
            chk = ((which == 0) ? chk_even : chk_odd) ^ b;
            if (l) begin
                compare(which == 0 ? "loopback_even" : "loopback_odd", int'(chk), which);
                chk = 1'b0;
            end
            if (which == 0) chk_even = chk;
            else chk_odd = chk;
        end
    endtask

    // The loopback parity checker is cleared by each tx_last, which also clears it ahead of the next frame.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk_even = 1'b0;
            chk_odd  = 1'b0;
            run_len  = 0;
        end else begin
            checkOutput(0, bus_even.tx_bit, bus_even.tx_valid, bus_even.tx_last);
            checkOutput(1, bus_odd.tx_bit, bus_odd.tx_valid, bus_odd.tx_last);
            if (bus_even.tx_valid) begin
                run_len++;
            end else if (run_len != 0) begin
                last_run = run_len;
                run_len  = 0;
            end
        end
    end

    task automatic checkReset(input string tag);
        compare({tag, "_tx_bit"}, int'({bus_even.tx_bit, bus_odd.tx_bit}), 0);
        compare({tag, "_tx_valid"}, int'({bus_even.tx_valid, bus_odd.tx_valid}), 0);
        compare({tag, "_tx_last"}, int'({bus_even.tx_last, bus_odd.tx_last}), 0);
        compare({tag, "_ready"}, int'({bus_even.ready_out, bus_odd.ready_out}), 3);
    endtask

    task automatic applyStimulus(input logic [DATA_W-1:0] w, input bit keep_valid);
        bit done;
        done = 1'b0;
        bus_even.data_in  = w;
        bus_even.valid_in = 1'b1;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (bus_even.ready_out) begin
                pushFrame(w);
                done = 1'b1;
            end
        end
        if (!done) compare("accept_timeout", int'(bus_even.ready_out), 1);
        @(posedge clk);
        #1;
        if (!keep_valid) begin
            bus_even.valid_in = 1'b0;
            bus_even.data_in  = DATA_W'($urandom);
        end
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            bus_even.data_in = DATA_W'($urandom);
        end
    endtask

    task automatic waitIdle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (q_even.size() == 0 && q_odd.size() == 0 && !bus_even.tx_valid && !bus_odd.tx_valid)
                done = 1'b1;
        end
        if (!done) compare("drain_timeout", q_even.size() + q_odd.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit b2b;
        bus_even.data_in  = '0;
        bus_even.valid_in = 1'b0;
        #1;
        checkReset("power_on");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        applyStimulus(8'hA5, 1'b0);
        waitIdle();
        compare("frame_len_a5", last_run, DATA_W + 1);
        applyStimulus(8'h07, 1'b0);
        waitIdle();
        compare("frame_len_07", last_run, DATA_W + 1);

        applyStimulus(8'h01, 1'b1);
        applyStimulus(8'hFF, 1'b0);
        waitIdle();
        compare("b2b_run", last_run, 2 * (DATA_W + 1));

        // Abort a frame mid-DATA, checking the async clear before any clock edge arrives.
        applyStimulus(8'h3C, 1'b0);
        idleCycles(3);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkReset("async_reset");
        q_even.delete();
        q_odd.delete();
        @(posedge clk);
        #1;
        checkReset("held_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(8'h5A, 1'b0);
        waitIdle();
        compare("frame_len_after_reset", last_run, DATA_W + 1);

        for (int n = 0; n < 200; n++) begin
            b2b = (n == 199) ? 1'b0 : 1'($urandom_range(0, 1));
            applyStimulus(DATA_W'($urandom), b2b);
            if (!b2b) idleCycles($urandom_range(0, 12));
        end
        waitIdle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
